// File: rtl/rf_bist.sv
// Two-pass self-test initiator for a 2R/1W register file: writes PAT+i, reads back in pairs, then repeats with the complement.
// Optional RF_BIST_STOP_ON_ERR_EN ends the run at the first mismatching read pair.
module rf_bist #(
  parameter int            AW      = 5,
  parameter int            DW      = 32,
  parameter logic [DW-1:0] PAT     = 32'hA5A5_0000,
  parameter bit            R0_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    err_cnt,
  output logic [AW-1:0] fail_addr,
  output logic          rf_we,
  output logic [AW-1:0] rf_rw,
  output logic [DW-1:0] rf_rd,
  output logic [AW-1:0] rf_ra,
  output logic [AW-1:0] rf_rb,
  input  logic [DW-1:0] rf_qa,
  input  logic [DW-1:0] rf_qb
);

  localparam int NREG  = 2**AW;
  localparam int NPAIR = NREG / 2;

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_FIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          pass_b_q, pass_b_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_rw_q, rf_rw_d;
  logic [DW-1:0] rf_rd_q, rf_rd_d;
  logic [AW-1:0] rf_ra_q, rf_ra_d;
  logic [AW-1:0] rf_rb_q, rf_rb_d;

  logic          mis_a, mis_b, stop_err;
  logic [8:0]    err_sum;
  logic [AW-1:0] idx_nxt;

  function automatic logic [DW-1:0] pat_data(input logic inv, input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = PAT + DW'(a);
    return inv ? ~v : v;
  endfunction

  function automatic logic [DW-1:0] exp_data(input logic inv, input logic [AW-1:0] a);
    if (R0_ZERO && a == '0) return '0;
    return pat_data(inv, a);
  endfunction

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pass_b_d    = pass_b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    rf_we_d     = 1'b0;
    rf_rw_d     = rf_rw_q;
    rf_rd_d     = rf_rd_q;
    rf_ra_d     = rf_ra_q;
    rf_rb_d     = rf_rb_q;
    idx_nxt     = idx_q + AW'(1);
    mis_a       = 1'b0;
    mis_b       = 1'b0;
    stop_err    = 1'b0;
    err_sum     = {1'b0, err_cnt_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_WR;
          idx_d       = '0;
          pass_b_d    = 1'b0;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          err_cnt_d   = '0;
          fail_addr_d = '0;
          rf_we_d     = 1'b1;
          rf_rw_d     = '0;
          rf_rd_d     = pat_data(1'b0, '0);
        end
      end
      S_WR: begin
        if (idx_q == AW'(NREG - 1)) begin
          state_d = S_RD;
          idx_d   = '0;
          rf_ra_d = AW'(0);
          rf_rb_d = AW'(1);
        end else begin
          idx_d   = idx_nxt;
          rf_we_d = 1'b1;
          rf_rw_d = idx_nxt;
          rf_rd_d = pat_data(pass_b_q, idx_nxt);
        end
      end
      S_RD: begin
        // Read data is combinational from the registered addresses, so compare this cycle.
        mis_a     = rf_qa != exp_data(pass_b_q, rf_ra_q);
        mis_b     = rf_qb != exp_data(pass_b_q, rf_rb_q);
        err_sum   = {1'b0, err_cnt_q} + 9'(mis_a) + 9'(mis_b);
        err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
        if ((mis_a || mis_b) && err_cnt_q == 8'd0)
          fail_addr_d = mis_a ? rf_ra_q : rf_rb_q;
`ifdef RF_BIST_STOP_ON_ERR_EN
        stop_err = mis_a | mis_b;
`else
        stop_err = 1'b0;
`endif
        if (idx_q == AW'(NPAIR - 1) && !pass_b_q && !stop_err) begin
          state_d  = S_WR;
          pass_b_d = 1'b1;
          idx_d    = '0;
          rf_we_d  = 1'b1;
          rf_rw_d  = '0;
          rf_rd_d  = pat_data(1'b1, '0);
        end else if (idx_q == AW'(NPAIR - 1) || stop_err) begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == 8'd0);
        end else begin
          idx_d   = idx_nxt;
          rf_ra_d = {idx_nxt[AW-2:0], 1'b0};
          rf_rb_d = {idx_nxt[AW-2:0], 1'b1};
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      pass_b_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      rf_we_q     <= 1'b0;
      rf_rw_q     <= '0;
      rf_rd_q     <= '0;
      rf_ra_q     <= '0;
      rf_rb_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pass_b_q    <= pass_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
      rf_we_q     <= rf_we_d;
      rf_rw_q     <= rf_rw_d;
      rf_rd_q     <= rf_rd_d;
      rf_ra_q     <= rf_ra_d;
      rf_rb_q     <= rf_rb_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign fail_addr = fail_addr_q;
  assign rf_we     = rf_we_q;
  assign rf_rw     = rf_rw_q;
  assign rf_rd     = rf_rd_q;
  assign rf_ra     = rf_ra_q;
  assign rf_rb     = rf_rb_q;

endmodule

// File: tb/tb_rf_bist.sv
// Bench for rf_bist: behavioural rf with injectable faults, reference model of expected results, scoreboard on done.
module tb_rf_bist;
  localparam int          AW   = 5;
  localparam int          DW   = 32;
  localparam int          NREG = 32;
  localparam logic [31:0] PAT  = 32'hA5A5_0000;

  logic          clk, rst_n, start;
  logic          busy, done, pass;
  logic [7:0]    err_cnt;
  logic [AW-1:0] fail_addr;
  logic          rf_we;
  logic [AW-1:0] rf_rw, rf_ra, rf_rb;
  logic [DW-1:0] rf_rd, rf_qa, rf_qb;

  rf_bist #(.AW(AW), .DW(DW), .PAT(PAT), .R0_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .fail_addr(fail_addr),
    .rf_we(rf_we), .rf_rw(rf_rw), .rf_rd(rf_rd),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_qa(rf_qa), .rf_qb(rf_qb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model with optional stuck-at bit and optional non-hardwired R0
  logic [31:0] mem [NREG];
  logic        r0_hard, flt_en, flt_val;
  logic [4:0]  flt_reg, flt_bit;

  function automatic logic [31:0] rd_view(input logic [4:0] a, input logic [31:0] v,
                                          input logic r0h, input logic fen, input logic [4:0] freg,
                                          input logic [4:0] fbit, input logic fval);
    logic [31:0] r;
    r = v;
    if (r0h && a == 5'd0) r = '0;
    if (fen && a == freg) r[fbit] = fval;
    return r;
  endfunction

  always @(posedge clk) if (rf_we) mem[rf_rw] <= rf_rd;
  assign rf_qa = rd_view(rf_ra, mem[rf_ra], r0_hard, flt_en, flt_reg, flt_bit, flt_val);
  assign rf_qb = rd_view(rf_rb, mem[rf_rb], r0_hard, flt_en, flt_reg, flt_bit, flt_val);

  typedef struct {
    int err;
    int fa;
    int ps;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk, n_fail, done_cnt, busy_cnt;

  task automatic chk(input string nm, input longint act, input longint req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Expected outcome derived directly from the pattern rules: what each register should read vs what the rf returns
  function automatic exp_t ref_model(input bit r0h, input bit fen, input int freg, input int fbit, input bit fval);
    exp_t e;
    int   errs;
    bit   stop;
    errs  = 0;
    stop  = 1'b0;
    e.fa  = 0;
    e.lat = 0;
    for (int p = 0; p < 2 && !stop; p++) begin
      e.lat += NREG;
      for (int j = 0; j < NREG / 2 && !stop; j++) begin
        e.lat++;
        for (int k = 0; k < 2; k++) begin
          int          a;
          logic [31:0] d, want, got;
          a = 2 * j + k;
          d = PAT + 32'(a);
          if (p == 1) d = ~d;
          want = (a == 0) ? 32'd0 : d;
          got  = (r0h && a == 0) ? 32'd0 : d;
          if (fen && a == freg) got[fbit] = fval;
          if (got != want) begin
            if (errs == 0) e.fa = a;
            errs++;
          end
        end
`ifdef RF_BIST_STOP_ON_ERR_EN
        if (errs > 0) stop = 1'b1;
`endif
      end
    end
    e.err = (errs > 255) ? 255 : errs;
    e.ps  = (errs == 0) ? 1 : 0;
    return e;
  endfunction

  // Monitor: counts busy cycles, checks each done against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      chk("we_outside_busy", rf_we & ~busy, 0);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("err_cnt", err_cnt, e.err);
          chk("fail_addr", fail_addr, e.fa);
          chk("pass", pass, e.ps);
          chk("busy_cycles", busy_cnt, e.lat);
          chk("busy_at_done", busy, 0);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_test(input bit r0h, input bit fen, input int freg, input int fbit,
                          input bit fval, input bit extra);
    int d0;
    r0_hard = r0h;
    flt_en  = fen;
    flt_reg = 5'(freg);
    flt_bit = 5'(fbit);
    flt_val = fval;
    exp_q.push_back(ref_model(r0h, fen, freg, fbit, fval));
    d0 = done_cnt;
    start = 1'b1;
    step(1);
    start = 1'b0;
    if (extra) begin
      step(4);
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(54);
      start = 1'b1;
      step(1);
      start = 1'b0;
    end
    for (int c = 0; c < 300 && done_cnt == d0; c++) step(1);
    chk("done_seen", done_cnt - d0, 1);
    step($urandom_range(1, 5));
  endtask

  initial begin
    int d0;
    n_chk    = 0;
    n_fail   = 0;
    done_cnt = 0;
    busy_cnt = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    r0_hard  = 1'b1;
    flt_en   = 1'b0;
    flt_reg  = '0;
    flt_bit  = '0;
    flt_val  = 1'b0;
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_fail_addr", fail_addr, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_rw", rf_rw, 0);
    chk("rst_rf_rd", rf_rd, 0);
    chk("rst_rf_ra", rf_ra, 0);
    chk("rst_rf_rb", rf_rb, 0);
    rst_n = 1'b1;
    step(2);

    run_test(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);  // fault-free
    run_test(1'b1, 1'b1, 7, 3, 1'b1, 1'b0);  // R7 bit3 stuck-at-1
    run_test(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);  // R0 stores data

    // Reset during WR at busy cycle 20
    d0    = done_cnt;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(19);
    rst_n = 1'b0;
    step(1);
    chk("midrst_rf_we", rf_we, 0);
    chk("midrst_busy", busy, 0);
    rst_n = 1'b1;
    step(110);
    chk("midrst_no_done", done_cnt - d0, 0);

    run_test(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    run_test(1'b1, 1'b0, 0, 0, 1'b0, 1'b1);  // extra starts while busy

    for (int n = 0; n < 10; n++)
      run_test($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, NREG - 1),
               $urandom_range(0, 31), $urandom_range(0, 1) == 1, 1'b0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
